// File: rtl/traffic_conflict_monitor_if.sv
// Signal-head bus between the signal controller side and the conflict monitor.
interface traffic_conflict_monitor_if;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic       fault_ack;
    logic       fault;
    logic [2:0] fault_code;
    logic       flash;

    modport master (
        output hwy, cntry, fault_ack,
        input  fault, fault_code, flash
    );

    modport slave (
        input  hwy, cntry, fault_ack,
        output fault, fault_code, flash
    );
endinterface

// File: rtl/traffic_conflict_monitor.sv
// Independent safety monitor for the highway/country signal heads: detects the first
// unsafe condition, latches its code and requests flash-red until a safe acknowledge.
module traffic_conflict_monitor #(
    parameter int unsigned MIN_YELLOW      = 3,
    parameter int unsigned MIN_ALLRED      = 2,
    parameter int unsigned CNTRY_MAX_GREEN = 32,
    parameter int unsigned FLASH_HALF      = 4,
    parameter int unsigned CW              = 8
) (
    input  logic                        clock,
    input  logic                        clear,
    traffic_conflict_monitor_if.slave   bus
);

    localparam logic [1:0] RED = 2'd0;
    localparam logic [1:0] YEL = 2'd1;
    localparam logic [1:0] GRN = 2'd2;
    localparam logic [1:0] BAD = 2'd3;

    localparam logic [CW-1:0] MIN_Y     = CW'(MIN_YELLOW);
    localparam logic [CW-1:0] MIN_AR    = CW'(MIN_ALLRED);
    localparam logic [CW-1:0] MAX_G     = CW'(CNTRY_MAX_GREEN);
    localparam logic [CW-1:0] FLASH_TOP = CW'(FLASH_HALF - 1);

    typedef enum logic [1:0] {
        ST_ARM   = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t        state;
    logic [1:0]    prev_hwy;
    logic [1:0]    prev_cntry;
    logic [CW-1:0] yel_hwy;
    logic [CW-1:0] yel_cntry;
    logic [CW-1:0] allred_cnt;
    logic [CW-1:0] green_cnt;
    logic [CW-1:0] flash_cnt;
    logic          fault_q;
    logic [2:0]    fault_code_q;
    logic          flash_q;

    logic          chk_conflict, chk_encoding, chk_sequence;
    logic          chk_short_yel, chk_short_ar, chk_overstay;
    logic [2:0]    viol_code;
    logic          both_red;
    logic [CW-1:0] base_yh, base_yc, base_ar, base_g;
    logic [CW-1:0] yel_hwy_nx, yel_cntry_nx, allred_nx, green_nx;

    function automatic logic bad_seq(input logic [1:0] p, input logic [1:0] c);
        return (p == GRN && c == RED) || (p == RED && c == YEL) || (p == YEL && c == GRN);
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt,
                                              input logic [CW-1:0] limit,
                                              input logic          hit);
        if (!hit)
            return '0;
        return (cnt >= limit) ? limit : cnt + CW'(1);
    endfunction

    // Violation detection against the previous sample and run-length history
    always_comb begin
        chk_conflict  = (bus.hwy != RED) && (bus.cntry != RED);
        chk_encoding  = (bus.hwy == BAD) || (bus.cntry == BAD);
        chk_sequence  = bad_seq(prev_hwy, bus.hwy) || bad_seq(prev_cntry, bus.cntry);
        chk_short_yel = (prev_hwy == YEL && bus.hwy == RED && yel_hwy < MIN_Y) ||
                        (prev_cntry == YEL && bus.cntry == RED && yel_cntry < MIN_Y);
        chk_short_ar  = ((prev_hwy == RED && bus.hwy == GRN) ||
                         (prev_cntry == RED && bus.cntry == GRN)) && (allred_cnt < MIN_AR);
        chk_overstay  = (bus.cntry == GRN) && (green_cnt >= MAX_G);

        viol_code = 3'd0;
        if (state == ST_ARM) begin
            if      (chk_conflict) viol_code = 3'd1;
            else if (chk_encoding) viol_code = 3'd2;
        end else if (state == ST_RUN) begin
            if      (chk_conflict)  viol_code = 3'd1;
            else if (chk_encoding)  viol_code = 3'd2;
            else if (chk_sequence)  viol_code = 3'd3;
            else if (chk_short_yel) viol_code = 3'd4;
            else if (chk_short_ar)  viol_code = 3'd5;
            else if (chk_overstay)  viol_code = 3'd6;
        end
    end

    // History update; ARM seeds the counters from the current sample alone
    always_comb begin
        both_red     = (bus.hwy == RED) && (bus.cntry == RED);
        base_yh      = (state == ST_ARM) ? '0 : yel_hwy;
        base_yc      = (state == ST_ARM) ? '0 : yel_cntry;
        base_ar      = (state == ST_ARM) ? '0 : allred_cnt;
        base_g       = (state == ST_ARM) ? '0 : green_cnt;
        yel_hwy_nx   = sat_inc(base_yh, MIN_Y, bus.hwy == YEL);
        yel_cntry_nx = sat_inc(base_yc, MIN_Y, bus.cntry == YEL);
        allred_nx    = sat_inc(base_ar, MIN_AR, both_red);
        green_nx     = sat_inc(base_g, MAX_G, bus.cntry == GRN);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state        <= ST_ARM;
            prev_hwy     <= RED;
            prev_cntry   <= RED;
            yel_hwy      <= '0;
            yel_cntry    <= '0;
            allred_cnt   <= '0;
            green_cnt    <= '0;
            flash_cnt    <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= 3'd0;
            flash_q      <= 1'b0;
        end else begin
            prev_hwy   <= bus.hwy;
            prev_cntry <= bus.cntry;
            yel_hwy    <= yel_hwy_nx;
            yel_cntry  <= yel_cntry_nx;
            allred_cnt <= allred_nx;
            green_cnt  <= green_nx;

            case (state)
                ST_ARM, ST_RUN: begin
                    if (viol_code != 3'd0) begin
                        state        <= ST_FAULT;
                        fault_q      <= 1'b1;
                        fault_code_q <= viol_code;
                        flash_q      <= 1'b1;
                        flash_cnt    <= '0;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_FAULT: begin
                    if (bus.fault_ack && both_red) begin
                        state        <= ST_ARM;
                        fault_q      <= 1'b0;
                        fault_code_q <= 3'd0;
                        flash_q      <= 1'b0;
                        flash_cnt    <= '0;
                    end else if (flash_cnt >= FLASH_TOP) begin
                        flash_q   <= ~flash_q;
                        flash_cnt <= '0;
                    end else begin
                        flash_cnt <= flash_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_ARM;
                end
            endcase
        end
    end

    assign bus.fault      = fault_q;
    assign bus.fault_code = fault_code_q;
    assign bus.flash      = flash_q;

endmodule
